pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/pipe_scoreboard.sv | 50 +++++
 rtl/pipe_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control blocks: controller state
// encoding and the number of stages drained after a HALT issues.
package pipe_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // EXE, MEM and WB must empty before the run is complete
   localparam int DRAIN_DEPTH = 3;
   localparam int DCW         = $clog2(DRAIN_DEPTH + 1);

endpackage

// File: rtl/pipe_scoreboard.sv
// Register pending-write scoreboard: one bit per architectural register,
// set on issue of a writer, cleared on write-back. Register 0 never pends.
module pipe_scoreboard #(
   parameter int RFW = 5
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clr_all,
   input  logic           set_en,
   input  logic [RFW-1:0] set_addr,
   input  logic           clr_en,
   input  logic [RFW-1:0] clr_addr,
   input  logic [RFW-1:0] rd_addr_a,
   input  logic [RFW-1:0] rd_addr_b,
   output logic           rd_a,
   output logic           rd_b
);

   localparam int NREG = 1 << RFW;

   logic [NREG-1:0] pend_reg;
   logic [NREG-1:0] pend_next;

   // Per-bit next value: clear-all first, then set beats clear on a collision
   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_bit
         if (gi == 0) begin : g_zero
            assign pend_next[gi] = 1'b0;
         end else begin : g_reg
            assign pend_next[gi] = clr_all                                ? 1'b0 :
                                   (set_en && (set_addr == RFW'(gi)))     ? 1'b1 :
                                   (clr_en && (clr_addr == RFW'(gi)))     ? 1'b0 :
                                   pend_reg[gi];
         end
      end
   endgenerate

   // Pending vector register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_reg <= '0;
      end else begin
         pend_reg <= pend_next;
      end
   end

   assign rd_a = pend_reg[rd_addr_a];
   assign rd_b = pend_reg[rd_addr_b];

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: sequences a run (load PC, run, drain after HALT),
// stalls the front end on RAW hazards against pending writes, and counts
// hazard stall cycles.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int RFW  = 5,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            id_valid,
   input  logic [RFW-1:0]  id_rs1,
   input  logic [RFW-1:0]  id_rs2,
   input  logic            id_rs1_used,
   input  logic            id_rs2_used,
   input  logic [RFW-1:0]  id_rd,
   input  logic            id_rd_we,
   input  logic            id_halt,
   input  logic            wb_we,
   input  logic [RFW-1:0]  wb_rd,
   input  logic            mem_stall,
   output logic            pc_load,
   output logic            pc_en,
   output logic            if_id_en,
   output logic            id_exe_bubble,
   output logic            pipe_en,
   output logic            busy,
   output logic            done,
   output logic [CNTW-1:0] stall_cnt
);

   state_t          state_reg, state_next;
   logic [CNTW-1:0] stall_cnt_reg, stall_cnt_next;
   logic [DCW-1:0]  drain_cnt_reg, drain_cnt_next;

   logic pend_rs1;
   logic pend_rs2;
   logic hazard;
   logic issue;
   logic sb_set_en;
   logic sb_clr_en;
   logic sb_clr_all;

   // Hazard uses only the registered pending bits; no write-back bypass
   assign hazard = id_valid & ((id_rs1_used & pend_rs1) | (id_rs2_used & pend_rs2));
   assign issue  = (state_reg == ST_RUN) & id_valid & ~hazard & ~mem_stall;

   // HALT enters the pipe as a bubble, so it never claims a destination
   assign sb_set_en  = issue & id_rd_we & ~id_halt & (id_rd != '0);
   assign sb_clr_en  = wb_we & (wb_rd != '0) & (state_reg != ST_LOAD);
   assign sb_clr_all = (state_reg == ST_LOAD);

   pipe_scoreboard #(
      .RFW (RFW)
   ) u_scoreboard (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_all   (sb_clr_all),
      .set_en    (sb_set_en),
      .set_addr  (id_rd),
      .clr_en    (sb_clr_en),
      .clr_addr  (wb_rd),
      .rd_addr_a (id_rs1),
      .rd_addr_b (id_rs2),
      .rd_a      (pend_rs1),
      .rd_b      (pend_rs2)
   );

   // State, stall counter and drain counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         stall_cnt_reg <= '0;
         drain_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         stall_cnt_reg <= stall_cnt_next;
         drain_cnt_reg <= drain_cnt_next;
      end
   end

   // Next-state and output decode from registered state plus live inputs
   always_comb begin
      state_next     = state_reg;
      stall_cnt_next = stall_cnt_reg;
      drain_cnt_next = drain_cnt_reg;
      pc_load        = 1'b0;
      pc_en          = 1'b0;
      if_id_en       = 1'b0;
      id_exe_bubble  = 1'b0;
      pipe_en        = 1'b0;
      busy           = 1'b0;
      done           = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (start) state_next = ST_LOAD;
         end
         ST_LOAD: begin
            busy           = 1'b1;
            pc_load        = 1'b1;
            stall_cnt_next = '0;
            drain_cnt_next = '0;
            state_next     = ST_RUN;
         end
         ST_RUN: begin
            busy          = 1'b1;
            pipe_en       = ~mem_stall;
            pc_en         = ~mem_stall & ~hazard;
            if_id_en      = ~mem_stall & ~hazard;
            id_exe_bubble = ~mem_stall & hazard;
            if (hazard && !mem_stall && (stall_cnt_reg != '1)) begin
               stall_cnt_next = stall_cnt_reg + CNTW'(1);
            end
            if (issue && id_halt) begin
               id_exe_bubble  = 1'b1;
               drain_cnt_next = DCW'(DRAIN_DEPTH);
               state_next     = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            busy          = 1'b1;
            id_exe_bubble = 1'b1;
            pipe_en       = ~mem_stall;
            if (!mem_stall) begin
               drain_cnt_next = drain_cnt_reg - DCW'(1);
               if (drain_cnt_reg == DCW'(1)) state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            done = 1'b1;
            if (start) state_next = ST_LOAD;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign stall_cnt = stall_cnt_reg;

endmodule
